reduce_tree_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 8-input OR reduction gate.
- Reduces a WIDTH-bit word to one bit with a per-beat selectable operation: OR, AND, XOR or NOR.
- Each tree level is registered, so wide zero-detect (ALU zr flag) and parity checks can be pipelined.
- Uses a valid/ready handshake. Sits between datapath producers, such as the ALU or memory-mapped I/O, and flag/condition consumers.

---
 rtl/hack_pkg.sv | 24 ++
 rtl/reduce_tree_pipe_level.sv | 50 +++++
 rtl/reduce_tree_pipe.sv | 80 ++++++++
 tb/tb_reduce_tree_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared op encoding and helpers for the reduction tree.
package hack_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // Identity element used to pad odd-sized levels (NOR runs as OR in the tree).
  function automatic logic identity(input op_e op);
    return (op == OP_AND);
  endfunction

  // Number of bits held after k halvings of a w-bit word (ceil at each step).
  function automatic int unsigned level_width(input int unsigned w, input int unsigned k);
    int unsigned n;
    n = w;
    for (int unsigned i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

endpackage

// File: rtl/reduce_tree_pipe_level.sv
// reduce_level: one registered tree level combining adjacent pairs of N input bits.
module reduce_level
  import hack_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter bit          LAST = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   adv,
  input  logic                   in_valid,
  input  op_e                    in_op,
  input  logic [N-1:0]           in_data,
  output logic                   out_valid,
  output op_e                    out_op,
  output logic [(N+1)/2-1:0]     out_data
);

  localparam int unsigned NO = (N + 1) / 2;

  logic [2*NO-1:0] padded;
  logic [NO-1:0]   nxt;

  always_comb begin
    padded         = {(2*NO){identity(in_op)}};
    padded[N-1:0]  = in_data;
    nxt            = '0;
    for (int unsigned i = 0; i < NO; i++) begin
      case (in_op)
        OP_AND:  nxt[i] = padded[2*i] & padded[2*i+1];
        OP_XOR:  nxt[i] = padded[2*i] ^ padded[2*i+1];
        default: nxt[i] = padded[2*i] | padded[2*i+1];
      endcase
    end
    if (LAST && in_op == OP_NOR) nxt = ~nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op    <= OP_OR;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_op    <= in_op;
      out_data  <= nxt;
    end
  end

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined OR/AND/XOR/NOR word reduction, one register per tree level.
// Optional sticky result flag: define REDUCE_TREE_STICKY_EN.
module reduce_tree_pipe
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y
`ifdef REDUCE_TREE_STICKY_EN
  ,
  input  logic             sticky_clr,
  output logic             sticky_y
`endif
);

  localparam int unsigned LEVELS = (WIDTH <= 1) ? 1 : $clog2(WIDTH);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned NI = level_width(WIDTH, k);
    localparam int unsigned NO = level_width(WIDTH, k + 1);

    logic          v;
    op_e           op;
    logic [NO-1:0] d;

    if (k == 0) begin : g_first
      reduce_level #(.N(NI), .LAST(k == LEVELS - 1)) u_level (
        .clk       (clk),
        .reset     (reset),
        .adv       (advance),
        .in_valid  (in_valid && in_ready),
        .in_op     (op_e'(in_op)),
        .in_data   (in_data),
        .out_valid (v),
        .out_op    (op),
        .out_data  (d)
      );
    end else begin : g_next
      reduce_level #(.N(NI), .LAST(k == LEVELS - 1)) u_level (
        .clk       (clk),
        .reset     (reset),
        .adv       (advance),
        .in_valid  (g_lvl[k-1].v),
        .in_op     (g_lvl[k-1].op),
        .in_data   (g_lvl[k-1].d),
        .out_valid (v),
        .out_op    (op),
        .out_data  (d)
      );
    end
  end

  assign out_valid = g_lvl[LEVELS-1].v;
  assign out_y     = g_lvl[LEVELS-1].d[0];

  // The last level has already applied its op (NOR inversion), so its op register has no reader.
  logic unused_last_op;
  assign unused_last_op = ^g_lvl[LEVELS-1].op;

`ifdef REDUCE_TREE_STICKY_EN
  always_ff @(posedge clk) begin
    if (reset)                              sticky_y <= 1'b0;
    else if (out_valid && out_ready && out_y) sticky_y <= 1'b1;
    else if (sticky_clr)                    sticky_y <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed self-checking bench for reduce_tree_pipe (WIDTH=8 and WIDTH=5 instances).
module tb_reduce_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       iv8, ir8, ov8, ordy8, y8;
  logic [7:0] d8;
  logic [1:0] op8;
  logic       iv5, ir5, ov5, ordy5, y5;
  logic [4:0] d5;
  logic [1:0] op5;
`ifdef REDUCE_TREE_STICKY_EN
  logic clr8, st8, clr5, st5;
`endif

  int errors = 0;
  int checks = 0;

  reduce_tree_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .in_data(d8), .in_op(op8),
    .out_valid(ov8), .out_ready(ordy8), .out_y(y8)
`ifdef REDUCE_TREE_STICKY_EN
    , .sticky_clr(clr8), .sticky_y(st8)
`endif
  );

  reduce_tree_pipe #(.WIDTH(5)) dut5 (
    .clk(clk), .reset(reset), .in_valid(iv5), .in_ready(ir5), .in_data(d5), .in_op(op5),
    .out_valid(ov5), .out_ready(ordy5), .out_y(y5)
`ifdef REDUCE_TREE_STICKY_EN
    , .sticky_clr(clr5), .sticky_y(st5)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back stream, WIDTH=8: FF/AND, FE/AND, 07/XOR, 00/NOR
  logic [7:0] s8_d   [4] = '{8'hFF, 8'hFE, 8'h07, 8'h00};
  logic [1:0] s8_op  [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
  logic       s8_y   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  // WIDTH=5: 1F/AND, 10/XOR, 0E/AND, 10/NOR
  logic [4:0] s5_d   [4] = '{5'h1F, 5'h10, 5'h0E, 5'h10};
  logic [1:0] s5_op  [4] = '{2'b01, 2'b10, 2'b01, 2'b11};
  logic       s5_y   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  // Backpressure beats
  logic [7:0] bp_d   [6] = '{8'h01, 8'h00, 8'hF0, 8'hFF, 8'h80, 8'hFE};
  logic [1:0] bp_op  [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
  logic       bp_y   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int recv;
    reset = 1'b1;
    iv8 = 1'b0; d8 = '0; op8 = '0; ordy8 = 1'b1;
    iv5 = 1'b0; d5 = '0; op5 = '0; ordy5 = 1'b1;
`ifdef REDUCE_TREE_STICKY_EN
    clr8 = 1'b0; clr5 = 1'b0;
`endif
    tick();
    tick();
    check("reset_out_valid", ov8, 1'b0);
    check("reset_out_y", y8, 1'b0);
    check("reset_in_ready", ir8, 1'b1);
    check("reset_out_valid5", ov5, 1'b0);
    reset = 1'b0;

    // OR 00 then 10 on consecutive cycles
    iv8 = 1'b1; op8 = 2'b00; d8 = 8'h00;
    tick();
    d8 = 8'h10;
    tick();
    iv8 = 1'b0;
    check("or_t2_valid", ov8, 1'b0);
    tick();
    check("or_t3_valid", ov8, 1'b1);
    check("or_t3_y", y8, 1'b0);
    tick();
    check("or_t4_valid", ov8, 1'b1);
    check("or_t4_y", y8, 1'b1);
    tick();
    check("or_t5_valid", ov8, 1'b0);

    // Mixed-op stream, WIDTH=8
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        iv8 = 1'b1; d8 = s8_d[i]; op8 = s8_op[i];
      end else begin
        iv8 = 1'b0;
      end
      tick();
      if (i >= 2) begin
        check($sformatf("mix8_valid%0d", i - 2), ov8, 1'b1);
        check($sformatf("mix8_y%0d", i - 2), y8, s8_y[i-2]);
      end
    end
    tick();
    check("mix8_drained", ov8, 1'b0);

    // WIDTH=5 padding checks
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        iv5 = 1'b1; d5 = s5_d[i]; op5 = s5_op[i];
      end else begin
        iv5 = 1'b0;
      end
      tick();
      if (i >= 2) begin
        check($sformatf("w5_valid%0d", i - 2), ov5, 1'b1);
        check($sformatf("w5_y%0d", i - 2), y5, s5_y[i-2]);
      end
    end

    // Backpressure: fill, stall 4 cycles, release, collect in order
    sent = 0;
    recv = 0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      ordy8 = !(c >= 3 && c < 7);
      if (sent < 6) begin
        iv8 = 1'b1; d8 = bp_d[sent]; op8 = bp_op[sent];
      end else begin
        iv8 = 1'b0;
      end
      #1;
      if (c >= 3 && c < 7) begin
        check($sformatf("bp_stall_in_ready%0d", c), ir8, 1'b0);
        check($sformatf("bp_stall_valid%0d", c), ov8, 1'b1);
        check($sformatf("bp_stall_y%0d", c), y8, bp_y[0]);
      end
      if (ov8 && ordy8) begin
        check($sformatf("bp_y%0d", recv), y8, bp_y[recv]);
        recv++;
      end
      if (iv8 && ir8) sent++;
      tick();
    end
    iv8 = 1'b0;
    ordy8 = 1'b1;
    check("bp_all_delivered", recv, 6);
    check("bp_all_sent", sent, 6);
    tick();
    check("bp_drained", ov8, 1'b0);

    // Reset with beats in flight; the beat presented with reset is lost
    iv8 = 1'b1; d8 = 8'h01; op8 = 2'b00;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_flush_valid", ov8, 1'b0);
    check("rst_flush_y", y8, 1'b0);
    d8 = 8'h80; op8 = 2'b10;
    tick();
    iv8 = 1'b0;
    check("rst_after1_valid", ov8, 1'b0);
    tick();
    check("rst_after2_valid", ov8, 1'b0);
    tick();
    check("rst_after3_valid", ov8, 1'b1);
    check("rst_after3_y", y8, 1'b1);
    tick();
    check("rst_after4_valid", ov8, 1'b0);

`ifdef REDUCE_TREE_STICKY_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("sticky_reset", st8, 1'b0);
    iv8 = 1'b1; d8 = 8'h01; op8 = 2'b00;
    tick();
    iv8 = 1'b0;
    tick();
    check("sticky_before", st8, 1'b0);
    tick();
    check("sticky_beat_visible", ov8, 1'b1);
    tick();
    check("sticky_set", st8, 1'b1);
    iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    check("sticky_beat2_y", y8, 1'b1);
    clr8 = 1'b1;
    tick();
    check("sticky_clr_vs_set", st8, 1'b1);
    tick();
    clr8 = 1'b0;
    check("sticky_cleared", st8, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
